seq_array_multiplier: RTL and testbench

Parametrised, iterative multiplier for the calculator datapath. It replaces the fully unrolled 16-row array with a single registered row that is reused over several cycles. Each cycle it ANDs ROWS_PER_CYCLE bits of B with A and accumulates them into a shifting partial-product register. It supports unsigned and signed (two's complement) modes and uses a start/done handshake, so the calculator control FSM can launch one multiply and wait for the result.

---
 rtl/seq_array_multiplier.sv | 147 ++++++++++++++
 tb/tb_seq_array_multiplier.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_array_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_array_multiplier: iterative signed/unsigned multiplier with a single  |
// | reusable partial-product row; start/done handshake. Rev 1.0               |
// +--------------------------------------------------------------------------+
module seq_array_multiplier #(
  parameter int WIDTH          = 16,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf
);

  localparam int C_STEPS = WIDTH / ROWS_PER_CYCLE;
  localparam int C_CNT_W = $clog2(C_STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 ovf_q, ovf_d;

  logic [2*WIDTH-1:0]   w_acc_step;
  logic [WIDTH:0]       w_row_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH:0]       w_sign_bits;
  logic                 w_ovf;

  // Each row adds into the upper half and shifts right by one; the row's
  // carry-out becomes the new MSB, so no accumulator bit is ever dropped.
  always_comb begin
    w_acc_step = acc_q;
    w_row_sum  = '0;
    for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
      w_row_sum  = {1'b0, w_acc_step[2*WIDTH-1:WIDTH]}
                 + {1'b0, a_q & {WIDTH{b_q[i]}}};
      w_acc_step = {w_row_sum, w_acc_step[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_prod      = neg_q ? -acc_q : acc_q;
    w_sign_bits = w_prod[2*WIDTH-1:WIDTH-1];
    if (mode_q) w_ovf = ~((&w_sign_bits) | (~|w_sign_bits));
    else        w_ovf = |w_prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Magnitudes are unsigned, so |-2^(W-1)| wraps to exactly 2^(W-1).
          a_d     = (signed_mode & a[WIDTH-1]) ? -a : a;
          b_d     = (signed_mode & b[WIDTH-1]) ? -b : b;
          neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          mode_d  = signed_mode;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == C_CNT_W'(C_STEPS)) begin
          product_d = w_prod;
          ovf_d     = w_ovf;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          acc_d = w_acc_step;
          b_d   = b_q >> ROWS_PER_CYCLE;
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_array_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_array_multiplier: two instances (R=1, R=4) at WIDTH=16 against an  |
// | arithmetic reference model. Rev 1.0                                       |
// +--------------------------------------------------------------------------+
module tb_seq_array_multiplier;

  logic        clk;
  logic        reset;
  logic        start_v  [2];
  logic        mode_v   [2];
  logic [15:0] a_v      [2];
  logic [15:0] b_v      [2];
  logic        busy_v   [2];
  logic        done_v   [2];
  logic [31:0] product_v[2];
  logic        ovf_v    [2];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int nsteps[2] = '{16, 4};

  seq_array_multiplier #(.WIDTH(16), .ROWS_PER_CYCLE(1)) u_dut_r1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .signed_mode(mode_v[0]),
    .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .product(product_v[0]), .ovf(ovf_v[0])
  );

  seq_array_multiplier #(.WIDTH(16), .ROWS_PER_CYCLE(4)) u_dut_r4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .signed_mode(mode_v[1]),
    .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .product(product_v[1]), .ovf(ovf_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic m,
                                output logic [31:0] p, output logic o);
    longint s;
    if (m) begin
      s = longint'($signed(x)) * longint'($signed(y));
      o = (s > 32767) || (s < -32768);
    end else begin
      s = longint'(x) * longint'(y);
      o = (s > 65535);
    end
    p = s[31:0];
  endfunction

  // Launches one multiply, scrambles the inputs after acceptance, and counts
  // edges until done (bounded at 100).
  task automatic run_op(input int d, input logic [15:0] x, input logic [15:0] y, input logic m,
                        output logic [31:0] p, output logic o, output int lat, output logic bsy);
    @(negedge clk);
    start_v[d] = 1'b1; a_v[d] = x; b_v[d] = y; mode_v[d] = m;
    @(posedge clk); #1;
    bsy = busy_v[d];
    start_v[d] = 1'b0; a_v[d] = 16'($urandom); b_v[d] = 16'($urandom); mode_v[d] = ~m;
    lat = 0;
    while (done_v[d] !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    p = product_v[d];
    o = ovf_v[d];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; mode_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total_cnt++;
      if ({busy_v[d], done_v[d], product_v[d], ovf_v[d]} !== 35'd0)
        $display("FAIL reset_state dut%0d: busy=%b done=%b product=%h ovf=%b, expected all zero",
                 d, busy_v[d], done_v[d], product_v[d], ovf_v[d]);
      else pass_cnt++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] xs[5] = '{16'hFFFF, 16'h8000, 16'hFFFD, 16'h0000, 16'h0001};
    logic [15:0] ys[5] = '{16'hFFFF, 16'h8000, 16'h0007, 16'h1234, 16'h1234};
    logic        ms[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ep[5] = '{32'hFFFE0001, 32'h40000000, 32'hFFFFFFEB, 32'h0, 32'h00001234};
    logic        eo[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] p;
    logic        o, bsy;
    int          lat;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 5; k++) begin
        run_op(d, xs[k], ys[k], ms[k], p, o, lat, bsy);
        total_cnt++;
        if (p !== ep[k] || o !== eo[k])
          $display("FAIL directed%0d dut%0d: product=%h ovf=%b, expected product=%h ovf=%b",
                   k, d, p, o, ep[k], eo[k]);
        else pass_cnt++;
        total_cnt++;
        if (lat !== nsteps[d] + 1 || bsy !== 1'b1)
          $display("FAIL latency%0d dut%0d: latency=%0d busy=%b, expected latency=%0d busy=1",
                   k, d, lat, bsy, nsteps[d] + 1);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      start_v[d] = 1'b1; a_v[d] = 16'd12; b_v[d] = 16'd10; mode_v[d] = 1'b0;
      @(posedge clk); #1;
      a_v[d] = 16'd500; b_v[d] = 16'd3;
      lat = 0;
      while (done_v[d] !== 1'b1 && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      total_cnt++;
      if (product_v[d] !== 32'd120 || lat !== nsteps[d] + 1)
        $display("FAIL busy_ignore dut%0d: product=%0d latency=%0d, expected product=120 latency=%0d",
                 d, product_v[d], lat, nsteps[d] + 1);
      else pass_cnt++;
      // start is still high, so the DONE cycle accepts the held operands.
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      total_cnt++;
      if (busy_v[d] !== 1'b1 || product_v[d] !== 32'd120)
        $display("FAIL b2b_accept dut%0d: busy=%b product=%0d, expected busy=1 product=120",
                 d, busy_v[d], product_v[d]);
      else pass_cnt++;
      lat = 0;
      while (done_v[d] !== 1'b1 && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      total_cnt++;
      if (product_v[d] !== 32'd1500 || lat !== nsteps[d] + 1)
        $display("FAIL b2b_result dut%0d: product=%0d latency=%0d, expected product=1500 latency=%0d",
                 d, product_v[d], lat, nsteps[d] + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] p;
    logic        o, bsy;
    int          lat;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      start_v[d] = 1'b1; a_v[d] = 16'h00FF; b_v[d] = 16'h00FF; mode_v[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start_v[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if ({busy_v[d], done_v[d], product_v[d], ovf_v[d]} !== 35'd0)
        $display("FAIL mid_run_reset dut%0d: busy=%b done=%b product=%h ovf=%b, expected all zero",
                 d, busy_v[d], done_v[d], product_v[d], ovf_v[d]);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      run_op(d, 16'h00FF, 16'h00FF, 1'b0, p, o, lat, bsy);
      total_cnt++;
      if (p !== 32'h0000FE01 || o !== 1'b0 || lat !== nsteps[d] + 1)
        $display("FAIL after_reset dut%0d: product=%h ovf=%b latency=%0d, expected 0000fe01/0/%0d",
                 d, p, o, lat, nsteps[d] + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [15:0] corners[4] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF};
    logic [15:0] x, y;
    logic [31:0] p, ep;
    logic        o, eo, bsy;
    int          lat;
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 200; k++) begin
          x = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
          y = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
          model(x, y, m[0], ep, eo);
          run_op(d, x, y, m[0], p, o, lat, bsy);
          total_cnt++;
          if (p !== ep || o !== eo || lat !== nsteps[d] + 1)
            $display("FAIL random dut%0d mode=%0d a=%h b=%h: product=%h ovf=%b lat=%0d, expected %h/%b/%0d",
                     d, m, x, y, p, o, lat, ep, eo, nsteps[d] + 1);
          else pass_cnt++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
